// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and port identifiers for the CPU data-memory path.
// Revision 1.0
`default_nettype none

package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant with a port-1 priority override.
// Revision 1.0
`default_nettype none

module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  input  logic       prio1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[1] && (prio1 || !req[0])) begin
      gnt = 2'b10;
    end else if (req[0] && (!req[1] || last == PORT_LDR)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      // both requesting, port 0 went last
      gnt = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0)
// and a loader/debug master (port 1). Revision 1.0
`default_nettype none

module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int              CNT_W     = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  port_id_t         last;
  port_id_t         rd_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             lock_hold;
  logic             rd_pend;
  logic             prio1;
  logic [1:0]       arb_gnt;
  logic             gnt0;
  logic             gnt1;

  // lock_hold marks that the previous grant was a locked port-1 grant
  assign prio1 = lock_hold && (burst_cnt < BURST_LIM);

  rr_arb2 u_rr_arb2 (
    .req   ({m1_req_i, m0_req_i}),
    .last  (last),
    .prio1 (prio1),
    .gnt   (arb_gnt)
  );

  assign gnt0     = arb_gnt[0] & rst_i;
  assign gnt1     = arb_gnt[1] & rst_i;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign mem_en_o = gnt0 | gnt1;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt0) begin
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
    end else if (gnt1) begin
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last      <= PORT_LDR;
      burst_cnt <= '0;
      lock_hold <= 1'b0;
      rd_pend   <= 1'b0;
      rd_owner  <= PORT_CPU;
    end else begin
      if (gnt0) begin
        last      <= PORT_CPU;
        burst_cnt <= '0;
        lock_hold <= 1'b0;
      end else if (gnt1) begin
        last      <= PORT_LDR;
        lock_hold <= m1_lock_i;
        if (!m1_lock_i) begin
          burst_cnt <= '0;
        end else if (m0_req_i && lock_hold && burst_cnt < BURST_LIM) begin
          // only grants won through the lock while port 0 waits count
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        burst_cnt <= '0;
        lock_hold <= 1'b0;
      end
      rd_pend <= (gnt0 & ~m0_we_i) | (gnt1 & ~m1_we_i);
      if (gnt0 | gnt1) begin
        rd_owner <= gnt1 ? PORT_LDR : PORT_CPU;
      end
    end
  end

  assign m0_rvalid_o = rd_pend && (rd_owner == PORT_CPU);
  assign m1_rvalid_o = rd_pend && (rd_owner == PORT_LDR);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// synchronous-read memory model. Revision 1.0
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_lock_i   (m1_lock),
    .m0_gnt_o    (m0_gnt),
    .m1_gnt_o    (m1_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m1_rvalid_o (m1_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_rdata_o  (m1_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Data memory model, preloaded while reset is held
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0]    <= 32'd100;
      mem[1]    <= 32'd200;
      mem[2]    <= 32'd42;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle();
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    drive_m0(1'b1, 1'b0, 32'h8, '0);
    #2;
    check("rst_gnt0", m0_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rvalid0", m0_rvalid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single port-0 read of word 2
    drive_m0(1'b1, 1'b0, 32'h8, '0);
    #3;
    check("t1_gnt0", m0_gnt, 1);
    check("t1_gnt1", m1_gnt, 0);
    check("t1_addr", mem_addr, 32'h8);
    check("t1_en", mem_en, 1);
    step(); idle(); #3;
    check("t1_rvalid0", m0_rvalid, 1);
    check("t1_rdata0", m0_rdata, 42);
    check("t1_rvalid1", m1_rvalid, 0);
    check("t1_rdata1", m1_rdata, 0);

    // continuous contention, port 0 went last so port 1 leads
    step();
    drive_m0(1'b1, 1'b0, 32'h0, '0);
    drive_m1(1'b1, 1'b0, 1'b0, 32'h4, '0);
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2 == 0);
      #3;
      check("t2_gnt1", m1_gnt, exp1);
      check("t2_gnt0", m0_gnt, !exp1);
      if (i > 0) begin
        check("t2_rvalid1", m1_rvalid, !exp1);
        check("t2_rvalid0", m0_rvalid, exp1);
        check("t2_rdata1", m1_rdata, exp1 ? 0 : 200);
        check("t2_rdata0", m0_rdata, exp1 ? 100 : 0);
      end
      step();
    end
    idle(); #3;
    check("t2_last_rvalid0", m0_rvalid, 1);
    check("t2_last_rdata0", m0_rdata, 100);

    // locked burst, BURST_MAX=2: three port-1 grants, then port 0
    step();
    for (int k = 0; k < 4; k++) begin
      drive_m0(1'b1, 1'b0, 32'h20, '0);
      drive_m1(1'b1, 1'b1, 1'b1, 32'(4 * k), 32'(8'h11 * (k + 1)));
      #3;
      check("t3_gnt1", m1_gnt, k < 3);
      check("t3_gnt0", m0_gnt, k == 3);
      if (k == 0) begin
        check("t3_we", mem_we, 1);
        check("t3_wdata", mem_wdata, 32'h11);
      end
      step();
    end
    idle(); #3;
    check("t3_rvalid0", m0_rvalid, 1);
    check("t3_rdata0", m0_rdata, 0);
    check("t3_mem0", mem[0], 32'h11);
    check("t3_mem1", mem[1], 32'h22);
    check("t3_mem2", mem[2], 32'h33);
    check("t3_mem3", mem[3], 0);

    // port-0 write then read back
    step();
    drive_m0(1'b1, 1'b1, 32'h4, 32'd7);
    #3;
    check("t4_wgnt0", m0_gnt, 1);
    check("t4_we", mem_we, 1);
    check("t4_wdata", mem_wdata, 7);
    step();
    drive_m0(1'b1, 1'b0, 32'h4, '0);
    #3;
    check("t4_no_rvalid", m0_rvalid, 0);
    check("t4_rgnt0", m0_gnt, 1);
    check("t4_rd_we", mem_we, 0);
    step(); idle(); #3;
    check("t4_rvalid0", m0_rvalid, 1);
    check("t4_rdata0", m0_rdata, 7);

    // reset asserted mid-cycle with a read returning and another requested
    step();
    drive_m0(1'b1, 1'b0, 32'h8, '0);
    #3;
    check("t5_gnt0", m0_gnt, 1);
    step();
    check("t5_pre_rvalid0", m0_rvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_rvalid0", m0_rvalid, 0);
    check("t5_rst_gnt0", m0_gnt, 0);
    check("t5_rst_en", mem_en, 0);
    step();
    step();
    rst_n = 1'b1;
    idle(); #3;
    check("t5_post_rvalid0", m0_rvalid, 0);
    step(); #3;
    check("t5_post2_rvalid0", m0_rvalid, 0);
    drive_m0(1'b1, 1'b0, 32'h0, '0);
    drive_m1(1'b1, 1'b0, 1'b0, 32'h4, '0);
    #1;
    check("t5_first_gnt0", m0_gnt, 1);
    check("t5_first_gnt1", m1_gnt, 0);
    step(); #3;
    check("t5_second_gnt1", m1_gnt, 1);
    check("t5_second_gnt0", m0_gnt, 0);
    step(); idle();
    step();

    // idle cycles
    for (int i = 0; i < 5; i++) begin
      #3;
      check("t6_en", mem_en, 0);
      check("t6_gnts", {m1_gnt, m0_gnt}, 0);
      check("t6_rvalids", {m1_rvalid, m0_rvalid}, 0);
      step();
    end

    // lock with port 0 absent must not consume the burst budget
    drive_m1(1'b1, 1'b1, 1'b1, 32'h30, 32'h5);
    for (int i = 0; i < 4; i++) begin
      #3;
      check("t7_solo_gnt1", m1_gnt, 1);
      step();
    end
    drive_m0(1'b1, 1'b0, 32'h0, '0);
    for (int k = 0; k < 3; k++) begin
      #3;
      check("t7_gnt1", m1_gnt, k < 2);
      check("t7_gnt0", m0_gnt, k == 2);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory of the single-cycle RISC-V CPU between the CPU load/store path (port 0) and a program/data loader or debug master (port 1). It grants one request per cycle using round-robin priority and supports bounded loader bursts. It routes synchronous-read data back to the requester that issued the read. It sits between the CPU datapath and the `Data_Memory` instance, inside the CPU top level.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data word width
- `BURST_MAX`, 4, maximum consecutive locked grants to port 1 while port 0 waits (≥1)

Ports:
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: reset, asynchronous, active-low
- `m0_req_i`, `m1_req_i` in 1: access request
- `m0_we_i`, `m1_we_i` in 1: 1 = write, 0 = read
- `m0_addr_i`, `m1_addr_i` in ADDR_W: address
- `m0_wdata_i`, `m1_wdata_i` in DATA_W: write data
- `m1_lock_i` in 1: port 1 requests burst continuation
- `m0_gnt_o`, `m1_gnt_o` out 1: request accepted this cycle
- `m0_rvalid_o`, `m1_rvalid_o` out 1: read data valid
- `m0_rdata_o`, `m1_rdata_o` out DATA_W: read data
- `mem_en_o` out 1: memory access strobe
- `mem_we_o` out 1: memory write enable
- `mem_addr_o` out ADDR_W: memory address
- `mem_wdata_o` out DATA_W: memory write data
- `mem_rdata_i` in DATA_W: memory read data, valid one cycle after a read strobe

## Operation
- Handshake: a transfer occurs on a rising edge where `mX_req_i & mX_gnt_o` is true. A requester holds its request fields stable until granted.
- Grants are combinational from the current requests and registered state. At most one grant is asserted per cycle. A grant requires the corresponding request.
- Round-robin: register `last` (0/1) holds the most recent granted port. When both ports request, the port ≠ `last` wins. Reset value of `last` is 1, so port 0 wins the first contention.
- Burst lock: if port 1 was granted with `m1_lock_i`=1, it keeps priority on the next cycle, even over port 0, while `burst_cnt` < `BURST_MAX`. `burst_cnt` increments on each locked port-1 grant made while `m0_req_i`=1. It clears on any port-0 grant, on any port-1 grant with lock=0, or on a cycle with no grant. When `burst_cnt` == `BURST_MAX` and port 0 requests, port 0 is granted and lock is ignored for that cycle.
- Memory side: `mem_en_o`=any grant. `mem_we_o`, `mem_addr_o`, `mem_wdata_o` mux from the granted port. They are all 0 when there is no grant.
- Read return: register `rd_pend` and `rd_owner` are set on a granted read. In the next cycle, `mX_rvalid_o`=1 for `rd_owner` only, and `mX_rdata_o`=`mem_rdata_i`. The non-owner `rdata_o` is 0. Writes produce no rvalid.
- Back-to-back reads are legal: each cycle's rvalid reflects the previous cycle's grant.

## Timing
- Grant latency: 0 cycles (same cycle as request when it wins).
- Read latency: rvalid exactly 1 cycle after the granting edge.
- Reset (`rst_i`=0, asynchronous) sets `last`=1, `burst_cnt`=0, `rd_pend`=0, and `rd_owner`=0. All rvalid outputs are 0 immediately.
- Grant and mem outputs during reset are combinational but forced to 0 while `rst_i`=0.
- A read granted in the cycle reset asserts is dropped: no rvalid after reset deassertion.
- Simultaneous requests after reset: port 0 granted first, then alternating each cycle while both keep requesting.
- A port-1 lock with no port-0 request never saturates `burst_cnt`.

## Structure
- Shared package `cpu_pkg` holds `ADDR_W`/`DATA_W` defaults and a port-id type (`PORT_CPU`=0, `PORT_LDR`=1).
- One natural sub-module: `rr_arb2`, a 2-requester round-robin grant with a priority-override input used for the burst lock. The read-return tracking and muxing stay in `dmem_arbiter`.

## Test plan
- Reset then single port-0 read at addr 0x8 with memory word 2 = 42 → `m0_gnt_o`=1 same cycle, `mem_addr_o`=0x8, next cycle `m0_rvalid_o`=1 with `m0_rdata_o`=42, and `m1_rvalid_o`=0.
- Both ports request reads continuously, no lock → grants alternate 0,1,0,1…. Each rvalid goes to the correct port one cycle later.
- Port 1 writes 0x11,0x22,0x33 to words 0–2 with lock=1 while port 0 requests; `BURST_MAX`=2 → port 1 granted 3 cycles, port 0 granted on cycle 4, and memory words hold the written values.
- Port-0 write 7 to addr 0x4, then read addr 0x4 → `mem_we_o`=1 on the first cycle, no rvalid after the write, and rvalid with 7 after the read.
- Assert `rst_i`=0 mid-cycle after a granted read → `m0_rvalid_o` drops to 0 immediately and stays 0 after release. The first contention after reset grants port 0.
- No requests for 5 cycles → `mem_en_o`=0, all grants and rvalids 0, `burst_cnt` stays 0.
